// File: rtl/adc_sequencer.sv
// Multi-channel ADC/AGC bring-up and run sequencer: loads ADC control words,
// waits on mbusy, enables acquisition and issues the AGC DAC load.
module adc_sequencer #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CTRL_W  = 10,
    parameter int unsigned AGC_W   = 12,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned T_LD    = 100,
    parameter int unsigned T_EN    = 900,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned RUN_LEN = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop_en,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*CTRL_W-1:0] ctrlword_in,
    input  logic [AGC_W-1:0]         agc_code_in,
    input  logic [NUM_CH-1:0]        adc_mbusy,
    input  logic                     agc_busy,
    output logic [NUM_CH*CTRL_W-1:0] adc_ctrlword,
    output logic [NUM_CH-1:0]        adc_ldctrl,
    output logic [NUM_CH-1:0]        adc_enable,
    output logic [AGC_W-1:0]         agc_data,
    output logic                     agc_load,
    output logic                     running,
    output logic                     done,
    output logic                     err_timeout
);

    if (T_LD < 1 || T_EN < 2 || TIMEOUT < 1 ||
        $clog2(T_LD + 1) > CNT_W || $clog2(T_EN + 1) > CNT_W ||
        $clog2(TIMEOUT + 1) > CNT_W || $clog2(RUN_LEN + 1) > CNT_W) begin : g_param_check
        $error("adc_sequencer: timing parameters out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(T_LD - 1);
    // The BUSY_WAIT cycle that sees mbusy clear is the first of the T_EN cycles.
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(T_EN - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'((RUN_LEN > 0) ? RUN_LEN - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        LOAD,
        BUSY_WAIT,
        EN_WAIT,
        RUN,
        STOP
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt;
    logic [NUM_CH*CTRL_W-1:0]  ctrl_q;
    logic [AGC_W-1:0]          agc_q;
    logic [NUM_CH-1:0]         mask_q;
    logic [NUM_CH-1:0]         ldctrl_q;
    logic [NUM_CH-1:0]         enable_q;
    logic                      err_q;
    logic                      pend;

    logic cnt_clr, capture, err_clr, to_set, ld_set, en_set, stop_set;
    logic busy_clr;

    assign busy_clr = ((adc_mbusy & mask_q) == '0);

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        capture  = 1'b0;
        err_clr  = 1'b0;
        to_set   = 1'b0;
        ld_set   = 1'b0;
        en_set   = 1'b0;
        stop_set = 1'b0;
        if (abort) begin
            state_n = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (start) begin
                        capture = 1'b1;
                        err_clr = 1'b1;
                        state_n = LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (cnt == LD_LAST) begin
                        ld_set  = 1'b1;
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    cnt_clr = 1'b1;
                    state_n = BUSY_WAIT;
                end
                BUSY_WAIT: begin
                    if (busy_clr) begin
                        cnt_clr = 1'b1;
                        state_n = EN_WAIT;
                    end else if (cnt == TO_LAST) begin
                        to_set  = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = IDLE;
                    end
                end
                EN_WAIT: begin
                    if (cnt == EN_LAST) begin
                        en_set  = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (RUN_LEN > 0 && cnt == RUN_LAST) begin
                        stop_set = 1'b1;
                        state_n  = STOP;
                    end
                end
                STOP: begin
                    cnt_clr = 1'b1;
                    state_n = loop_en ? LD_WAIT : IDLE;
                end
                default: begin
                    cnt_clr = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ctrl_q   <= '0;
            agc_q    <= '0;
            mask_q   <= '0;
            ldctrl_q <= '0;
            enable_q <= '0;
            err_q    <= 1'b0;
            pend     <= 1'b0;
        end else begin
            state <= state_n;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);
            if (capture) begin
                ctrl_q <= ctrlword_in;
                agc_q  <= agc_code_in;
                mask_q <= ch_mask;
            end
            if (err_clr)
                err_q <= 1'b0;
            else if (to_set)
                err_q <= 1'b1;
            ldctrl_q <= ld_set ? mask_q : '0;
            if (abort || stop_set)
                enable_q <= '0;
            else if (en_set)
                enable_q <= mask_q;
            // Load request stays pending until a cycle where the DAC link is free.
            if (abort || stop_set)
                pend <= 1'b0;
            else if (en_set)
                pend <= 1'b1;
            else if (!agc_busy)
                pend <= 1'b0;
        end
    end

    assign adc_ctrlword = ctrl_q;
    assign agc_data     = agc_q;
    assign adc_ldctrl   = ldctrl_q;
    assign adc_enable   = enable_q;
    assign agc_load     = pend & ~agc_busy;
    assign running      = (state == RUN);
    assign done         = (state == STOP);
    assign err_timeout  = err_q;

endmodule
